// File: rtl/digit_serial_alu_pkg.sv
// Shared types for the digit-serial ALU: command encoding and FSM states.
package alu_pkg;

    typedef enum logic [2:0] {
        ALU_ADD   = 3'd0,
        ALU_SUB   = 3'd1,
        ALU_AND   = 3'd2,
        ALU_OR    = 3'd3,
        ALU_XOR   = 3'd4,
        ALU_LSHFT = 3'd5,
        ALU_RSHFT = 3'd6,
        ALU_RSVD  = 3'd7
    } alu_cmd_t;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } alu_state_t;

endpackage

// File: rtl/digit_serial_alu_if.sv
// Request/result handshake bundle between a requester and the digit-serial ALU.
interface digit_serial_alu_if
    import alu_pkg::*;
#(
    parameter int WORD_W = 32
) ();

    logic              start_valid;
    logic              start_ready;
    alu_cmd_t          cmd;
    logic [WORD_W-1:0] word1;
    logic [WORD_W-1:0] word2;
    logic [WORD_W-1:0] result;
    logic              carry_out;
    logic              res_valid;
    logic              res_ready;

    modport master (
        output start_valid, cmd, word1, word2, res_ready,
        input  start_ready, result, carry_out, res_valid
    );

    modport slave (
        input  start_valid, cmd, word1, word2, res_ready,
        output start_ready, result, carry_out, res_valid
    );

endinterface

// File: rtl/digit_serial_alu_digit_counter.sv
// Up/down digit index with a last-digit flag; saturates at the final digit.
module digit_counter #(
    parameter int NDIG = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    load,
    input  logic                    down_in,
    input  logic                    step,
    output logic [$clog2(NDIG)-1:0] idx,
    output logic                    last
);

    localparam int               IDX_W   = $clog2(NDIG);
    localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(NDIG - 1);

    logic down_q;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx    <= '0;
            down_q <= 1'b0;
        end else if (load) begin
            down_q <= down_in;
            idx    <= down_in ? IDX_MAX : '0;
        end else if (step && !last) begin
            idx <= down_q ? idx - 1'b1 : idx + 1'b1;
        end
    end

    assign last = down_q ? (idx == '0) : (idx == IDX_MAX);

endmodule

// File: rtl/digit_serial_alu.sv
// Digit-serial ALU: one DIGIT_W slice per cycle, carry/shift bit chained between digits.
module digit_serial_alu
    import alu_pkg::*;
#(
    parameter int WORD_W  = 32,
    parameter int DIGIT_W = 4
) (
    input logic               clk,
    input logic               rst_n,
    digit_serial_alu_if.slave bus
);

    localparam int NDIG  = WORD_W / DIGIT_W;
    localparam int IDX_W = $clog2(NDIG);

    alu_state_t        state_q, state_d;
    alu_cmd_t          cmd_q;
    logic [WORD_W-1:0] a_q, b_q;
    logic              carry_q, carry_out_q;
    logic              start_ready, res_valid, running, accept;

    logic [IDX_W-1:0]   idx;
    logic               last;
    logic [DIGIT_W-1:0] res_dig_q [NDIG];
    wire  [DIGIT_W-1:0] a_dig [NDIG];
    wire  [DIGIT_W-1:0] b_dig [NDIG];
    wire  [WORD_W-1:0]  result_w;

    logic [DIGIT_W-1:0] a_cur, b_cur, b_op, dig_res;
    logic [DIGIT_W:0]   sum, shl, shr;
    logic               dig_carry;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (bus.start_valid) state_d = S_RUN;
            S_RUN:   if (last)            state_d = S_DONE;
            S_DONE:  if (bus.res_ready)   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: every combinational output gets a default first so no latch is inferred.
    always_comb begin
        start_ready = 1'b0;
        res_valid   = 1'b0;
        running     = 1'b0;
        case (state_q)
            S_IDLE:  start_ready = 1'b1;
            S_RUN:   running     = 1'b1;
            S_DONE:  res_valid   = 1'b1;
            default: ;
        endcase
    end

    assign accept = start_ready && bus.start_valid;

    digit_counter #(.NDIG(NDIG)) u_digit_counter (
        .clk     (clk),
        .rst_n   (rst_n),
        .load    (accept),
        .down_in (bus.cmd == ALU_RSHFT),
        .step    (running),
        .idx     (idx),
        .last    (last)
    );

    // Per-digit slice select and write-back; only the digit under the index is written.
    for (genvar g = 0; g < NDIG; g++) begin : g_digit
        assign a_dig[g] = a_q[g*DIGIT_W +: DIGIT_W];
        assign b_dig[g] = b_q[g*DIGIT_W +: DIGIT_W];
        assign result_w[g*DIGIT_W +: DIGIT_W] = res_dig_q[g];

        // NOTE: the result digits are plain flops, so each one is reset like any other state.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n)                              res_dig_q[g] <= '0;
            else if (accept)                         res_dig_q[g] <= '0;
            else if (running && idx == IDX_W'(g))    res_dig_q[g] <= dig_res;
        end
    end

    // Shifts ride the carry flop: LSHFT feeds the lower digit's MSB up, RSHFT feeds the upper LSB down.
    always_comb begin
        a_cur     = a_dig[idx];
        b_cur     = b_dig[idx];
        b_op      = (cmd_q == ALU_SUB) ? ~b_cur : b_cur;
        sum       = {1'b0, a_cur} + {1'b0, b_op} + {{DIGIT_W{1'b0}}, carry_q};
        shl       = {b_cur, carry_q};
        shr       = {carry_q, b_cur};
        dig_res   = a_cur;
        dig_carry = 1'b0;
        case (cmd_q)
            ALU_ADD, ALU_SUB: begin
                dig_res   = sum[DIGIT_W-1:0];
                dig_carry = sum[DIGIT_W];
            end
            ALU_AND: dig_res = a_cur & b_cur;
            ALU_OR:  dig_res = a_cur | b_cur;
            ALU_XOR: dig_res = a_cur ^ b_cur;
            ALU_LSHFT: begin
                dig_res   = shl[DIGIT_W-1:0];
                dig_carry = shl[DIGIT_W];
            end
            ALU_RSHFT: begin
                dig_res   = shr[DIGIT_W:1];
                dig_carry = shr[0];
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cmd_q       <= ALU_ADD;
            a_q         <= '0;
            b_q         <= '0;
            carry_q     <= 1'b0;
            carry_out_q <= 1'b0;
        end else if (accept) begin
            cmd_q       <= bus.cmd;
            a_q         <= bus.word1;
            b_q         <= bus.word2;
            carry_q     <= (bus.cmd == ALU_SUB);
            carry_out_q <= 1'b0;
        end else if (running) begin
            carry_q <= dig_carry;
            if (last) carry_out_q <= dig_carry;
        end
    end

    assign bus.start_ready = start_ready;
    assign bus.res_valid   = res_valid;
    assign bus.result      = result_w;
    assign bus.carry_out   = carry_out_q;

endmodule

// File: tb/tb_digit_serial_alu.sv
// Bench for digit_serial_alu: word-level reference model, per-cycle compare, directed corner cases.
module tb_digit_serial_alu;
    import alu_pkg::*;

    localparam int NDIG4 = 8;
    localparam int NDIG8 = 4;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    digit_serial_alu_if #(.WORD_W(32)) bus4 ();
    digit_serial_alu_if #(.WORD_W(32)) bus8 ();

    digit_serial_alu #(.WORD_W(32), .DIGIT_W(4)) u_dut4 (.clk(clk), .rst_n(rst_n), .bus(bus4));
    digit_serial_alu #(.WORD_W(32), .DIGIT_W(8)) u_dut8 (.clk(clk), .rst_n(rst_n), .bus(bus8));

    int n_checks = 0;
    int n_pass   = 0;
    int cycle    = 0;
    bit rand_rr  = 1'b0;

    logic [32:0] q_exp [$];
    int          q_acc [$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    // Whole-word reference: {carry_out, result}.
    function automatic logic [32:0] model(input logic [2:0] c, input logic [31:0] a, input logic [31:0] b);
        case (c)
            3'd0:    return {1'b0, a} + {1'b0, b};
            3'd1:    return {1'b0, a} + {1'b0, ~b} + 33'd1;
            3'd2:    return {1'b0, a & b};
            3'd3:    return {1'b0, a | b};
            3'd4:    return {1'b0, a ^ b};
            3'd5:    return {b[31], b << 1};
            3'd6:    return {b[0], b >> 1};
            default: return {1'b0, a};
        endcase
    endfunction

    function automatic logic [31:0] pick_word();
        case ($urandom_range(0, 5))
            0:       return 32'h0000_0000;
            1:       return 32'hffff_ffff;
            2:       return 32'h8000_0000;
            3:       return 32'h0000_0001;
            default: return $urandom;
        endcase
    endfunction

    always @(posedge clk) cycle++;

    // Per-cycle compare of dut4 against the queue-based model.
    always @(negedge clk) begin
        bit idle_exp, vld_exp;
        if (!rst_n) begin
            q_exp.delete();
            q_acc.delete();
        end else begin
            idle_exp = (q_exp.size() == 0);
            vld_exp  = 1'b0;
            if (!idle_exp) vld_exp = (cycle - q_acc[0]) >= NDIG4;
            check("start_ready", bus4.start_ready, idle_exp);
            check("res_valid", bus4.res_valid, vld_exp);
            if (vld_exp) begin
                check("sb_result", bus4.result, q_exp[0][31:0]);
                check("sb_carry", bus4.carry_out, q_exp[0][32]);
                if (bus4.res_ready) begin
                    void'(q_exp.pop_front());
                    void'(q_acc.pop_front());
                end
            end
            if (idle_exp && bus4.start_valid) begin
                q_exp.push_back(model(bus4.cmd, bus4.word1, bus4.word2));
                q_acc.push_back(cycle + 1);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        if (rand_rr) bus4.res_ready = ($urandom_range(0, 3) != 0);
    endtask

    task automatic send(input logic [2:0] c, input logic [31:0] a, input logic [31:0] b);
        bit ok;
        int tries;
        ok    = 1'b0;
        tries = 0;
        bus4.cmd         = alu_cmd_t'(c);
        bus4.word1       = a;
        bus4.word2       = b;
        bus4.start_valid = 1'b1;
        while (!ok && tries < 100) begin
            @(negedge clk);
            ok = bus4.start_ready;
            tick();
            tries++;
        end
        if (!ok) check("send_timeout", 1, 0);
        bus4.start_valid = 1'b0;
        bus4.cmd         = alu_cmd_t'($urandom_range(0, 7));
        bus4.word1       = $urandom;
        bus4.word2       = $urandom;
    endtask

    task automatic wait_valid(output int lat);
        lat = 0;
        while (!bus4.res_valid && lat < 50) begin
            tick();
            lat++;
        end
        if (!bus4.res_valid) check("valid_timeout", 1, 0);
    endtask

    task automatic directed(input string name, input logic [2:0] c, input logic [31:0] a,
                            input logic [31:0] b, input logic [31:0] exp_r, input logic exp_c);
        int lat;
        send(c, a, b);
        wait_valid(lat);
        check({name, "_result"}, bus4.result, exp_r);
        check({name, "_carry"}, bus4.carry_out, exp_c);
        check({name, "_latency"}, lat, NDIG4);
        tick();
    endtask

    initial begin
        int lat;
        int guard;
        rst_n = 1'b0;
        bus4.start_valid = 1'b0; bus4.cmd = ALU_ADD; bus4.word1 = '0; bus4.word2 = '0; bus4.res_ready = 1'b1;
        bus8.start_valid = 1'b0; bus8.cmd = ALU_ADD; bus8.word1 = '0; bus8.word2 = '0; bus8.res_ready = 1'b1;

        // Hand-computed values pinning the reference model.
        check("model_add_wrap", model(3'd0, 32'hffff_ffff, 32'h1), 33'h1_0000_0000);
        check("model_sub_borrow", model(3'd1, 32'h0, 32'h1), 33'h0_ffff_ffff);
        check("model_rshft", model(3'd6, 32'h0, 32'h0600_0001), 33'h1_0300_0000);
        check("model_rsvd", model(3'd7, 32'hdead_beef, 32'h1234_5678), 33'h0_dead_beef);

        repeat (3) @(posedge clk);
        #1;
        check("rst_result", bus4.result, 32'h0);
        check("rst_carry", bus4.carry_out, 1'b0);
        check("rst_res_valid", bus4.res_valid, 1'b0);
        check("rst_start_ready", bus4.start_ready, 1'b1);
        rst_n = 1'b1;
        tick();

        directed("add_efff", 3'd0, 32'hefff_ffff, 32'h0000_0001, 32'hf000_0000, 1'b0);
        directed("add_wrap", 3'd0, 32'hffff_ffff, 32'h0000_0001, 32'h0000_0000, 1'b1);
        directed("sub_5_3",  3'd1, 32'h0000_0005, 32'h0000_0003, 32'h0000_0002, 1'b1);
        directed("sub_0_1",  3'd1, 32'h0000_0000, 32'h0000_0001, 32'hffff_ffff, 1'b0);
        directed("rshft",    3'd6, 32'h1234_5678, 32'h0600_0001, 32'h0300_0000, 1'b1);
        directed("lshft",    3'd5, 32'h1234_5678, 32'h8000_0001, 32'h0000_0002, 1'b1);
        directed("xor",      3'd4, 32'hf0f0_a5a5, 32'hff00_5a5a, 32'h0ff0_ffff, 1'b0);
        directed("rsvd",     3'd7, 32'hcafe_f00d, 32'hffff_ffff, 32'hcafe_f00d, 1'b0);

        // Backpressure in DONE with start_valid pulsing.
        bus4.res_ready = 1'b0;
        send(3'd0, 32'h1234_5678, 32'h1111_1111);
        wait_valid(lat);
        for (int i = 0; i < 3; i++) begin
            bus4.start_valid = 1'b1;
            bus4.cmd         = ALU_XOR;
            bus4.word1       = $urandom;
            bus4.word2       = $urandom;
            tick();
            check("bp_result", bus4.result, 32'h2345_6789);
            check("bp_carry", bus4.carry_out, 1'b0);
            check("bp_start_ready", bus4.start_ready, 1'b0);
            check("bp_res_valid", bus4.res_valid, 1'b1);
        end
        bus4.start_valid = 1'b0;
        bus4.res_ready   = 1'b1;
        tick();
        check("bp_release_ready", bus4.start_ready, 1'b1);
        tick();
        check("bp_no_accept", bus4.start_ready, 1'b1);

        // Reset in the middle of RUN.
        send(3'd0, 32'hffff_0000, 32'h0000_ffff);
        repeat (3) tick();
        rst_n = 1'b0;
        #1;
        check("midrst_result", bus4.result, 32'h0);
        check("midrst_carry", bus4.carry_out, 1'b0);
        check("midrst_res_valid", bus4.res_valid, 1'b0);
        check("midrst_start_ready", bus4.start_ready, 1'b1);
        tick();
        rst_n = 1'b1;
        tick();
        directed("post_rst_add", 3'd0, 32'h0000_0001, 32'h0000_0001, 32'h0000_0002, 1'b0);

        // DIGIT_W=8 instance.
        bus8.cmd = ALU_ADD; bus8.word1 = 32'h00ff_00ff; bus8.word2 = 32'h0001_0001; bus8.start_valid = 1'b1;
        check("d8_start_ready", bus8.start_ready, 1'b1);
        tick();
        bus8.start_valid = 1'b0;
        bus8.word1 = $urandom;
        bus8.word2 = $urandom;
        lat = 0;
        while (!bus8.res_valid && lat < 50) begin
            tick();
            lat++;
        end
        check("d8_latency", lat, NDIG8);
        check("d8_result", bus8.result, 32'h0100_0100);
        check("d8_carry", bus8.carry_out, 1'b0);

        // Randomized traffic with random consumer stalls.
        rand_rr = 1'b1;
        repeat (200) begin
            send(3'($urandom_range(0, 7)), pick_word(), pick_word());
            repeat ($urandom_range(0, 2)) tick();
        end
        guard = 0;
        while (q_exp.size() != 0 && guard < 300) begin
            tick();
            guard++;
        end
        check("drain", q_exp.size(), 0);
        rand_rr        = 1'b0;
        bus4.res_ready = 1'b1;
        repeat (2) tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, %0d/%0d", n_pass, n_checks);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/digit_serial_alu.md
DIGIT_SERIAL_ALU -- requirements
Module: digit_serial_alu

Interface
REQ-001 The block SHALL have parameter WORD_W, default 32, operand and result width in bits.
REQ-002 The block SHALL have parameter DIGIT_W, default 4, digit width processed per cycle; WORD_W SHALL be a multiple of DIGIT_W, and NDIG = WORD_W/DIGIT_W SHALL be >= 2.
REQ-003 The block SHALL have port clk  input  1  the single clock, rising-edge active.
REQ-004 The block SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-005 The block SHALL have port start_valid  input  1  a request is present.
REQ-006 The block SHALL have port start_ready  output  1  the block accepts a request.
REQ-007 The block SHALL have port cmd  input  3  operation, of type AluCmd.
REQ-008 The block SHALL have port word1  input  WORD_W  operand A.
REQ-009 The block SHALL have port word2  input  WORD_W  operand B, also the shift source.
REQ-010 The block SHALL have port result  output  WORD_W  registered result.
REQ-011 The block SHALL have port carry_out  output  1  carry, not-borrow, or shifted-out bit.
REQ-012 The block SHALL have port res_valid  output  1  result and carry_out are valid.
REQ-013 The block SHALL have port res_ready  input  1  the consumer takes the result.

Function
REQ-014 Operations SHALL be: ADD = word1+word2; SUB = word1-word2, computed as word1+~word2+1; AND; OR; XOR; LSHFT = word2<<1; RSHFT = word2>>1, logical. Code 3'b111 SHALL be reserved and SHALL give result = word1, carry_out = 0.
REQ-015 The FSM SHALL have states IDLE, RUN, DONE; start_ready SHALL be 1 only in IDLE, and res_valid SHALL be 1 only in DONE.
REQ-016 IDLE: when start_valid=1 at a clock edge, the block SHALL latch cmd, word1, word2; clear result to 0; load the digit index; load the carry seed; and go to RUN.
REQ-017 The carry seed SHALL be 1 for SUB and 0 for all other commands.
REQ-018 The digit index SHALL start at 0 and increment (LSB->MSB) for every command except RSHFT, which SHALL start at NDIG-1 and decrement (MSB->LSB).
REQ-019 RUN: each cycle the block SHALL process exactly one DIGIT_W digit from the latched operands, write it into the same digit position of result, and register the inter-digit carry.
REQ-020 For the inter-digit carry:
  - ADD/SUB: the carry SHALL be the digit adder carry.
  - LSHFT: the incoming bit SHALL be the MSB of the previous lower digit; the first digit SHALL shift in 0.
  - RSHFT: the incoming bit SHALL be the LSB of the previous higher digit; the first digit SHALL shift in 0.
  - Logic ops: the carry SHALL be 0.
REQ-021 After the digit at the final index is processed, the block SHALL go to DONE.
  - carry_out SHALL be the final adder carry for ADD/SUB (1 = no borrow for SUB).
  - carry_out SHALL be word2[WORD_W-1] for LSHFT and word2[0] for RSHFT.
  - carry_out SHALL be 0 for logic ops.
REQ-022 Latency: for a request accepted at edge k, res_valid SHALL rise after edge k+NDIG; throughput SHALL be one operation per NDIG+2 cycles when res_ready is held at 1.
REQ-023 DONE: result and carry_out SHALL stay stable while res_ready=0; when res_ready=1 at an edge, the block SHALL return to IDLE.
REQ-024 start_valid in RUN or DONE SHALL be ignored, and changes on cmd, word1 or word2 after acceptance SHALL have no effect.
REQ-025 The digit index SHALL never leave the range 0..NDIG-1.

Reset
REQ-026 While rst_n=0, the block SHALL hold: state=IDLE, result=0, carry_out=0, res_valid=0, start_ready=1, digit index=0, and internal carry=0.
REQ-027 Reset asserted mid-RUN or in DONE SHALL abort the operation with no residual effect on the next request.

Structure
REQ-028 Package alu_pkg SHALL hold the AluCmd enum (ADD=0, SUB=1, AND=2, OR=3, XOR=4, LSHFT=5, RSHFT=6) and the FSM state typedef.
REQ-029 The digit index up/down counter SHALL be a sub-module digit_counter, parametrised by NDIG, with load, direction, and last-digit flag.
REQ-030 Digit select and digit write-back SHALL be parametrised generate logic, with no hard-coded case per digit.

Verification
REQ-031 ADD efff_ffff+0000_0001 -> result f000_0000, carry_out 0, with res_valid exactly 8 cycles after acceptance.
REQ-032 Carry and borrow cases:
  - ADD ffff_ffff+0000_0001 -> result 0000_0000, carry_out 1.
  - SUB 0000_0005-0000_0003 -> result 0000_0002, carry_out 1.
  - SUB 0-1 -> result ffff_ffff, carry_out 0.
REQ-033 Shift cases:
  - RSHFT word2=0600_0001 -> result 0300_0000, carry_out 1.
  - LSHFT word2=8000_0001 -> result 0000_0002, carry_out 1.
REQ-034 Backpressure: hold res_ready=0 for 3 cycles in DONE while pulsing start_valid -> result and carry_out unchanged, start_ready=0, no new request accepted.
REQ-035 Reset: assert rst_n=0 after 3 RUN cycles -> all outputs at reset values; then ADD 1+1 -> result 0000_0002.
REQ-036 Instance with DIGIT_W=8: ADD 00ff_00ff+0001_0001 -> result 0100_0100, with res_valid 4 cycles after acceptance.
